// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronise, debounce and arbitrate four buttons into one clean press
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = 19,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btns,
  output logic [1:0] num,
  output logic       pressed,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       multi_err
);
  typedef enum logic [1:0] {IDLE, HELD, LOCK} state_t;
  state_t state, state_n;
  logic [3:0] sr [SYNC_STAGES];
  logic [3:0] sync, stable;
  logic [CNT_W-1:0] cnt [4];
  logic onehot;
  logic [1:0] idx, num_n;
  logic pressed_n, pp_n, rp_n, me_n;
  assign sync = sr[SYNC_STAGES-1];
  // synchroniser shift chain, one column per button
  always_ff @(posedge clk) begin
    if (reset) for (int k = 0; k < SYNC_STAGES; k++) sr[k] <= '0;
    else begin
      sr[0] <= btns;
      for (int k = 1; k < SYNC_STAGES; k++) sr[k] <= sr[k-1];
    end
  end
  for (genvar g = 0; g < 4; g++) begin : g_db
    // stable flips only after the synchronised input differs for DEBOUNCE_CYCLES edges
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt[g] <= '0;
        stable[g] <= 1'b0;
      end else if (sync[g] == stable[g]) cnt[g] <= '0;
      else if (cnt[g] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable[g] <= sync[g];
        cnt[g] <= '0;
      end else cnt[g] <= cnt[g] + 1'b1;
    end
  end
  assign onehot = (stable != 4'd0) && ((stable & (stable - 4'd1)) == 4'd0);
  assign idx = stable[3] ? 2'd3 : stable[2] ? 2'd2 : stable[1] ? 2'd1 : 2'd0;
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      num <= 2'd0;
      pressed <= 1'b0;
      press_pulse <= 1'b0;
      release_pulse <= 1'b0;
      multi_err <= 1'b0;
    end else begin
      state <= state_n;
      num <= num_n;
      pressed <= pressed_n;
      press_pulse <= pp_n;
      release_pulse <= rp_n;
      multi_err <= me_n;
    end
  end
  // next-state: a held press survives other buttons; anything ambiguous goes to lockout
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = (stable == 4'd0) ? IDLE : onehot ? HELD : LOCK;
    else if (state == HELD) state_n = stable[num] ? HELD : (stable == 4'd0) ? IDLE : LOCK;
    else state_n = (stable == 4'd0) ? IDLE : LOCK;
  end
  // output values to be registered alongside the state
  always_comb begin
    num_n = (state == IDLE && state_n == HELD) ? idx : num;
    pressed_n = state_n == HELD;
    pp_n = state == IDLE && state_n == HELD;
    rp_n = state == HELD && state_n != HELD;
    me_n = state_n == LOCK;
  end
endmodule
